// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Summary  : Single-port frame-buffer arbiter that shares memory between a
//            4-word display prefetch FIFO and a host write port. Optional
//            underflow flag is built when VGA_FB_UNDERFLOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int FB_WORDS = 80000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              disp_ena,
    output logic [7:0]        pix_out,
    output logic              underflow,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_WORDS - 1);
    localparam logic [2:0]        c_depth     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [31:0]       fifo_mem_q [4];
    logic [31:0]       fifo_mem_d [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        fifo_cnt_q, fifo_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              rd_p1_q, rd_p1_d;
    logic              rd_p2_q, rd_p2_d;
    logic [7:0]        pix_q, pix_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [2:0]        w_level;
    logic              w_fetch_req;
    logic              w_fetch_gnt;
    logic              w_host_gnt;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_head;

    // Level counts reads still in the memory pipeline so the FIFO never overfills.
    always_comb begin
        w_level = fifo_cnt_q + {2'b00, rd_p1_q} + {2'b00, rd_p2_q};
    end

    always_comb begin
        w_fetch_req = 1'b0;
        w_host_gnt  = 1'b0;
        unique case (state_q)
            ST_IDLE:    w_host_gnt  = host_valid;
            ST_PREFILL: w_fetch_req = (w_level < c_depth);
            ST_RUN: begin
                if (w_level < 3'd2) begin
                    w_fetch_req = 1'b1;
                end else if (host_valid) begin
                    w_host_gnt = 1'b1;
                end else if (w_level < c_depth) begin
                    w_fetch_req = 1'b1;
                end
            end
            ST_DONE:    w_host_gnt  = host_valid;
            default:    w_fetch_req = 1'b0;
        endcase
    end

    // A fetch issued alongside frame_start would belong to the old frame.
    assign w_fetch_gnt = w_fetch_req & ~frame_start;
    assign host_ready  = w_host_gnt & rst;
    assign w_head      = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        idx_d        = idx_q;
        pix_d        = 8'd0;
        w_pop        = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        if (w_fetch_gnt) begin
            mem_en_d     = 1'b1;
            mem_addr_d   = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + 1'b1;
        end else if (w_host_gnt) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
        end

        rd_p1_d = w_fetch_gnt;
        rd_p2_d = rd_p1_q;
        w_push  = rd_p2_q & ~frame_start;

        if (disp_ena && (fifo_cnt_q != 3'd0)) begin
            pix_d = w_head[{idx_q, 3'b000} +: 8];
            idx_d = idx_q + 2'd1;
            w_pop = (idx_q == 2'd3);
        end

        if (w_push) begin
            fifo_mem_d[wr_ptr_q] = mem_rdata;
        end
        wr_ptr_d   = wr_ptr_q + {1'b0, w_push};
        rd_ptr_d   = rd_ptr_q + {1'b0, w_pop};
        fifo_cnt_d = fifo_cnt_q + {2'b00, w_push} - {2'b00, w_pop};

        unique case (state_q)
            ST_PREFILL: begin
                if (w_fetch_gnt && (fetch_addr_q == c_last_addr)) begin
                    state_d = ST_DONE;
                end else if (w_level == c_depth) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fetch_gnt && (fetch_addr_q == c_last_addr)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = state_q;
        endcase

        if (frame_start) begin
            state_d      = ST_PREFILL;
            fetch_addr_d = '0;
            wr_ptr_d     = 2'd0;
            rd_ptr_d     = 2'd0;
            fifo_cnt_d   = 3'd0;
            idx_d        = 2'd0;
            rd_p1_d      = 1'b0;
            rd_p2_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
            fifo_mem_q   <= '{default: '0};
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_cnt_q   <= 3'd0;
            idx_q        <= 2'd0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            pix_q        <= 8'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            idx_q        <= idx_d;
            rd_p1_q      <= rd_p1_d;
            rd_p2_q      <= rd_p2_d;
            pix_q        <= pix_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign pix_out   = pix_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef VGA_FB_UNDERFLOW_EN
    logic underflow_q, underflow_d;

    always_comb begin
        underflow_d = underflow_q | (disp_ena & (fifo_cnt_q == 3'd0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire
